// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider for MIPS div/divu.
// One quotient bit per clock; quotient goes to LO, remainder to HI.
//
// state | meaning
// IDLE  | waiting for start; the done cycle is also an IDLE cycle
// RUN   | WIDTH shift/subtract iterations on magnitudes
// FIX   | apply signs (or divide-by-zero values), register results, pulse done
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             dz_q;

  logic [WIDTH-1:0] dvd_abs_w;
  logic [WIDTH-1:0] dvs_abs_w;
  logic [WIDTH+1:0] shift_w;
  logic [WIDTH+1:0] trial_w;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] q_fix_d;
  logic [WIDTH-1:0] r_fix_d;

  // Operand magnitudes for the capture cycle (raw values when unsigned).
  always_comb begin
    dvd_abs_w = dividend;
    dvs_abs_w = divisor;
    if (signed_op && dividend[WIDTH-1]) dvd_abs_w = -dividend;
    if (signed_op && divisor[WIDTH-1])  dvs_abs_w = -divisor;
  end

  // One restoring step: shift in the next dividend bit, keep the trial if non-negative.
  // The partial remainder is always below the divisor, so one extra sign bit is enough.
  always_comb begin
    shift_w = {rem_q, quo_q[WIDTH-1]};
    trial_w = shift_w - {2'b00, dvs_q};
    if (trial_w[WIDTH+1]) begin
      rem_d = shift_w[WIDTH:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_d = trial_w[WIDTH:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  // Final result values; on divide-by-zero quo_q holds the raw dividend.
  always_comb begin
    if (dz_q) begin
      q_fix_d = '1;
      r_fix_d = quo_q;
    end else begin
      q_fix_d = qneg_q ? -quo_q : quo_q;
      r_fix_d = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dz_q        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            rem_q <= '0;
            if (divisor == '0) begin
              quo_q   <= dividend;
              dvs_q   <= '0;
              cnt_q   <= '0;
              qneg_q  <= 1'b0;
              rneg_q  <= 1'b0;
              dz_q    <= 1'b1;
              state_q <= S_FIX;
            end else begin
              quo_q   <= dvd_abs_w;
              dvs_q   <= dvs_abs_w;
              cnt_q   <= CW'(WIDTH);
              qneg_q  <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              rneg_q  <= signed_op & dividend[WIDTH-1];
              dz_q    <= 1'b0;
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= S_FIX;
        end
        S_FIX: begin
          quotient    <= q_fix_d;
          remainder   <= r_fix_d;
          div_by_zero <= dz_q;
          done        <= 1'b1;
          busy        <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative restoring divider for the MIPS datapath. Handles `div`/`divu` work that the single-cycle ALU cannot do in one cycle, acting as the inverse-operation companion to the ALU's arithmetic path. Takes a dividend/divisor pair on a start pulse and retires one quotient bit per clock. Returns quotient (LO) and remainder (HI) with a one-cycle done pulse.

## Interface
- `WIDTH`, default 32: operand and result width in bits; the iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request. Sampled only when the unit is idle (`busy`=0).
- `signed_op`  in  1  1 = signed (`div`), 0 = unsigned (`divu`). Captured with `start`.
- `dividend`  in  WIDTH  numerator. Captured with `start`.
- `divisor`  in  WIDTH  denominator. Captured with `start`.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; results are valid from this cycle.
- `quotient`  out  WIDTH  LO result; held until the next `done`.
- `remainder`  out  WIDTH  HI result; held until the next `done`.
- `div_by_zero`  out  1  qualifies the current held result; updated with each `done`.

## Operation
- States:
  - IDLE: accepts requests.
  - RUN: performs the WIDTH iterations.
  - FIX: applies signs and registers the results.
- IDLE, `start`=1, `divisor`≠0:
  - Capture absolute values when `signed_op`=1; otherwise capture raw values.
  - Capture the quotient sign as XOR of the operand MSBs, and the remainder sign as the dividend MSB. Both are 0 when unsigned.
  - Set the iteration counter to WIDTH and go to RUN.
- IDLE, `start`=1, `divisor`=0:
  - Go straight to FIX with the zero flag set. No iterations are run.
- RUN, each cycle:
  - Partial remainder is a (WIDTH+1)-bit register.
  - Shift {rem, quo} left by 1, bringing in the next dividend MSB.
  - Compute trial = rem − divisor.
  - If trial ≥ 0: rem ← trial and the quotient LSB = 1. Otherwise the quotient LSB = 0.
  - Decrement the counter. When the counter reaches 0, go to FIX.
- FIX, normal path:
  - Quotient is negated if the quotient sign is set; remainder is negated if the remainder sign is set.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - All arithmetic wraps modulo 2^WIDTH.
- FIX, divide by zero: `quotient` = all ones, `remainder` = `dividend` (raw), `div_by_zero` = 1.
- FIX, signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 (by wrap), remainder 0, `div_by_zero` = 0.
- FIX, exit: register the outputs, assert `done`, and return to IDLE.
- `start` while `busy`=1 is ignored. Input changes after capture have no effect.

## Timing
- Reset:
  - State goes to IDLE.
  - `busy`, `done`, `div_by_zero` = 0; `quotient`, `remainder` = 0.
  - Counter and internal registers are cleared.
  - Reset mid-operation aborts the operation: no `done` is produced, and the outputs return to 0.
- All outputs are registered.
- Normal latency: `start` sampled at edge k.
  - `busy`=1 after edge k.
  - RUN occupies edges k+1 … k+WIDTH.
  - FIX occurs at edge k+WIDTH+1: `done`=1 and `busy`=0 after that edge, for exactly one cycle.
  - Latency is WIDTH+1 cycles, i.e. 33 cycles for WIDTH=32.
- Divide-by-zero latency: `busy`=1 after edge k; `done` after edge k+1.
- The `done` cycle is an IDLE cycle. A `start` sampled at the next edge is accepted, so issue can be back-to-back with zero bubble.
- `quotient`, `remainder` and `div_by_zero` change only at the edge that raises `done`, or at reset.

## Test plan
- Unsigned: 100 / 7, `signed_op`=0.
  - Required: `done` 33 cycles after the start edge; quotient 14, remainder 2, `div_by_zero`=0.
- Signed: 0xFFFFFFF9 (−7) / 2, `signed_op`=1.
  - Required: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - The same operands unsigned give quotient 0x7FFFFFFC, remainder 1.
- Divide by zero: 0x12345678 / 0.
  - Required: `done` after 2 edges; quotient 0xFFFFFFFF, remainder 0x12345678, `div_by_zero`=1.
  - A following normal divide clears `div_by_zero`.
- Signed overflow: 0x80000000 / 0xFFFFFFFF, signed.
  - Required: quotient 0x80000000, remainder 0, no flag.
- Handshake:
  - A second `start` at cycle 10 of an operation (different operands) is ignored; exactly one `done`, carrying the first results.
  - A `start` held during the `done` cycle is accepted, and the next `done` arrives 33 cycles later.
- Reset: assert `rst` asynchronously mid-RUN (cycle 15).
  - Required: outputs immediately 0 and `busy`=0; no `done` afterwards; the next request completes correctly.
